// File: rtl/rom_boot_ctrl_pkg.sv
// Shared state encoding and instruction-memory geometry for the boot loader.
package rom_boot_ctrl_pkg;

    localparam int unsigned IMEM_DEPTH = 2048;
    localparam int unsigned IMEM_AW    = 11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCopy  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } boot_state_e;

    function automatic logic [31:0] word_byte_addr(input logic [31:0] idx);
        return idx << 2;
    endfunction

endpackage

// File: rtl/rom_boot_pipe.sv
// Valid/index delay line matching the code ROM read latency; registers the
// instruction-memory write strobe, byte address and data.
module rom_boot_pipe
    import rom_boot_ctrl_pkg::*;
#(
    parameter int unsigned AW      = IMEM_AW,
    parameter int unsigned SRC_LAT = 1
) (
    input  logic          clk_100MHz,
    input  logic          arst_n,
    input  logic          issue_vld,
    input  logic [AW-1:0] issue_idx,
    input  logic [31:0]   src_data,
    output logic          in_flight,
    output logic          w_ena,
    output logic [31:0]   w_addr,
    output logic [31:0]   w_data
);

    logic          vld_q [SRC_LAT];
    logic [AW-1:0] idx_q [SRC_LAT];

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < int'(SRC_LAT); i++) begin
                vld_q[i] <= 1'b0;
                idx_q[i] <= '0;
            end
            w_ena  <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            vld_q[0] <= issue_vld;
            idx_q[0] <= issue_idx;
            for (int i = 1; i < int'(SRC_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
            // The last delay stage lines up with the ROM data for its index.
            w_ena <= vld_q[SRC_LAT-1];
            if (vld_q[SRC_LAT-1]) begin
                w_addr <= word_byte_addr(32'(idx_q[SRC_LAT-1]));
                w_data <= src_data;
            end
        end
    end

    // Output register excluded: its write lands in the current cycle.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < int'(SRC_LAT); i++) begin
            in_flight = in_flight | vld_q[i];
        end
    end

endmodule

// File: rtl/rom_boot_ctrl.sv
// Copies the code ROM image into instruction memory and stalls the core until done.
// Optional ROM_BOOT_CHECKSUM_EN adds checksum_o, the 32-bit sum of all written words.
module rom_boot_ctrl
    import rom_boot_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH     = IMEM_DEPTH,
    parameter int unsigned AW        = IMEM_AW,
    parameter int unsigned SRC_LAT   = 1,
    parameter int unsigned AUTO_BOOT = 1
) (
    input  logic          clk_100MHz,
    input  logic          arst_n,
    input  logic          start_i,
    output logic [AW-1:0] src_addr_o,
    input  logic [31:0]   src_data_i,
    output logic          w_ena_o,
    output logic [31:0]   w_addr_o,
    output logic [31:0]   w_data_o,
    output logic          hold_o,
    output logic          busy_o,
`ifdef ROM_BOOT_CHECKSUM_EN
    output logic          done_o,
    output logic [31:0]   checksum_o
`else
    output logic          done_o
`endif
);

    boot_state_e   state_q;
    logic [AW-1:0] rd_ptr_q;
    logic          boot_q;
    logic          hold_q;
    logic          busy_q;
    logic          done_q;
    logic          in_flight;
    logic          launch;

    assign launch = (state_q == StIdle) && (boot_q || start_i);

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            boot_q   <= (AUTO_BOOT != 0);
            hold_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (launch) begin
                        state_q  <= StCopy;
                        rd_ptr_q <= '0;
                        boot_q   <= 1'b0;
                        hold_q   <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                StCopy: begin
                    // Stop on the last index rather than wrapping the pointer.
                    if (rd_ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= StDrain;
                    end else begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (!in_flight) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // A reload request stalls the core in the very cycle it is seen.
    assign hold_o     = hold_q | ((state_q == StIdle) && start_i);
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign src_addr_o = rd_ptr_q;

    rom_boot_pipe #(
        .AW      (AW),
        .SRC_LAT (SRC_LAT)
    ) u_pipe (
        .clk_100MHz (clk_100MHz),
        .arst_n     (arst_n),
        .issue_vld  (state_q == StCopy),
        .issue_idx  (rd_ptr_q),
        .src_data   (src_data_i),
        .in_flight  (in_flight),
        .w_ena      (w_ena_o),
        .w_addr     (w_addr_o),
        .w_data     (w_data_o)
    );

`ifdef ROM_BOOT_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            csum_q <= '0;
        end else if (launch) begin
            csum_q <= '0;
        end else if (w_ena_o) begin
            csum_q <= csum_q + w_data_o;
        end
    end

    assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_rom_boot_ctrl.sv
// Bench: two loaders (SRC_LAT 1 auto-boot, SRC_LAT 3 manual) against a timing/data model.
module tb_rom_boot_ctrl;

    localparam int D = 8;

    logic        clk;
    logic        rst_n;
    logic        start    [2];
    logic [2:0]  src_addr [2];
    logic [31:0] src_data [2];
    logic        w_ena    [2];
    logic [31:0] w_addr   [2];
    logic [31:0] w_data   [2];
    logic        hold     [2];
    logic        busy     [2];
    logic        done     [2];
`ifdef ROM_BOOT_CHECKSUM_EN
    logic [31:0] csum     [2];
    logic [31:0] m_sum    [2];
`endif

    logic [31:0] base [2];
    logic [31:0] rom_a;
    logic [31:0] rom_b [3];

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic        m_idle   [2] = '{1'b1, 1'b1};
    logic        m_boot   [2] = '{1'b0, 1'b0};
    logic        m_hold   [2] = '{1'b1, 1'b1};
    int          m_t      [2] = '{0, 0};
    int          m_loads  [2] = '{0, 0};
    int          m_launch [2] = '{0, 0};
    logic [31:0] m_last_addr [2];
    logic [31:0] m_last_data [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    rom_boot_ctrl #(.DEPTH(D), .AW(3), .SRC_LAT(1), .AUTO_BOOT(1)) u_dut_a (
        .clk_100MHz (clk),
        .arst_n     (rst_n),
        .start_i    (start[0]),
        .src_addr_o (src_addr[0]),
        .src_data_i (src_data[0]),
        .w_ena_o    (w_ena[0]),
        .w_addr_o   (w_addr[0]),
        .w_data_o   (w_data[0]),
        .hold_o     (hold[0]),
        .busy_o     (busy[0]),
`ifdef ROM_BOOT_CHECKSUM_EN
        .done_o     (done[0]),
        .checksum_o (csum[0])
`else
        .done_o     (done[0])
`endif
    );

    rom_boot_ctrl #(.DEPTH(D), .AW(3), .SRC_LAT(3), .AUTO_BOOT(0)) u_dut_b (
        .clk_100MHz (clk),
        .arst_n     (rst_n),
        .start_i    (start[1]),
        .src_addr_o (src_addr[1]),
        .src_data_i (src_data[1]),
        .w_ena_o    (w_ena[1]),
        .w_addr_o   (w_addr[1]),
        .w_data_o   (w_data[1]),
        .hold_o     (hold[1]),
        .busy_o     (busy[1]),
`ifdef ROM_BOOT_CHECKSUM_EN
        .done_o     (done[1]),
        .checksum_o (csum[1])
`else
        .done_o     (done[1])
`endif
    );

    // Synchronous-read ROMs, word k = base + k
    always @(posedge clk) begin
        rom_a    <= base[0] + 32'(src_addr[0]);
        rom_b[0] <= base[1] + 32'(src_addr[1]);
        rom_b[1] <= rom_b[0];
        rom_b[2] <= rom_b[1];
    end
    assign src_data[0] = rom_a;
    assign src_data[1] = rom_b[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a load leaving IDLE writes word k at t = lat+1+k, pulses done at t = D+lat+1.
    always @(negedge clk) begin : scoreboard
        int t;
        int k;
        int lat;
`ifdef ROM_BOOT_CHECKSUM_EN
        logic [31:0] exp_sum;
`endif
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 1 : 3;
            if (!rst_n) begin
                check_eq("rst_ena", 32'(w_ena[i]), 0);
                check_eq("rst_hold", 32'(hold[i]), 1);
                check_eq("rst_busy", 32'(busy[i]), 0);
                check_eq("rst_done", 32'(done[i]), 0);
                check_eq("rst_addr", w_addr[i], 0);
                check_eq("rst_data", w_data[i], 0);
                check_eq("rst_src", 32'(src_addr[i]), 0);
`ifdef ROM_BOOT_CHECKSUM_EN
                check_eq("rst_csum", csum[i], 0);
                m_sum[i] = '0;
`endif
                m_idle[i]      = 1'b1;
                m_boot[i]      = (i == 0);
                m_hold[i]      = 1'b1;
                m_last_addr[i] = '0;
                m_last_data[i] = '0;
            end else if (m_idle[i]) begin
                check_eq("idle_ena", 32'(w_ena[i]), 0);
                check_eq("idle_busy", 32'(busy[i]), 0);
                check_eq("idle_done", 32'(done[i]), 0);
                check_eq("idle_hold", 32'(hold[i]), 32'(m_hold[i] | start[i]));
                check_eq("idle_addr", w_addr[i], m_last_addr[i]);
                check_eq("idle_data", w_data[i], m_last_data[i]);
`ifdef ROM_BOOT_CHECKSUM_EN
                check_eq("idle_csum", csum[i], m_sum[i]);
`endif
                if (m_boot[i] || start[i]) begin
                    m_idle[i] = 1'b0;
                    m_boot[i] = 1'b0;
                    m_t[i]    = 0;
                    m_launch[i]++;
                end
            end else begin
                t = m_t[i];
                k = t - lat - 1;
                if (k >= 0 && k < D) begin
                    m_last_addr[i] = 32'(4 * k);
                    m_last_data[i] = base[i] + 32'(k);
                end
                check_eq("ena", 32'(w_ena[i]), 32'(k >= 0 && k < D));
                check_eq("addr", w_addr[i], m_last_addr[i]);
                check_eq("data", w_data[i], m_last_data[i]);
                check_eq("busy", 32'(busy[i]), 32'(t <= D + lat));
                check_eq("done", 32'(done[i]), 32'(t == D + lat + 1));
                check_eq("hold", 32'(hold[i]), 32'(t != D + lat + 1));
                if (t < D) check_eq("src_addr", 32'(src_addr[i]), 32'(t));
                if (t == D + lat + 1) begin
`ifdef ROM_BOOT_CHECKSUM_EN
                    exp_sum = '0;
                    for (int j = 0; j < D; j++) exp_sum = exp_sum + base[i] + 32'(j);
                    check_eq("done_csum", csum[i], exp_sum);
                    m_sum[i] = exp_sum;
`endif
                    m_hold[i] = 1'b0;
                    m_idle[i] = 1'b1;
                    m_loads[i]++;
                end else begin
                    m_t[i]++;
                end
            end
        end
    end

    task automatic pulse(input int i);
        @(posedge clk);
        #2 start[i] = 1'b1;
        @(posedge clk);
        #2 start[i] = 1'b0;
    endtask

    task automatic wait_loads(input int i, input int target);
        int n = 0;
        while (m_loads[i] < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (m_loads[i] < target) check_eq("wait_load_timeout", 32'(m_loads[i]), 32'(target));
    endtask

    // Reset A once k writes of its current load have been seen.
    task automatic reset_after_writes(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            #1 n++;
        end while (!(!m_idle[0] && m_t[0] == k + 2) && n < 100);
        if (n >= 100) check_eq("wait_copy_timeout", 32'(m_t[0]), 32'(k + 2));
        rst_n = 1'b0;
        #1;
        check_eq("abort_ena", 32'(w_ena[0]), 0);
        check_eq("abort_hold", 32'(hold[0]), 1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : stimulus
        int tgt;
        int sel;
        int l0;
        rst_n    = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        base[0]  = 32'hA500_0000;
        base[1]  = 32'hA500_0000;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_loads(0, 1);
        repeat (20) @(posedge clk);

        // Reload A, plus an ignored request mid-copy
        pulse(0);
        repeat (3) @(posedge clk);
        pulse(0);
        wait_loads(0, 2);

        pulse(1);
        wait_loads(1, 1);

        // Level start: two back-to-back loads
        l0  = m_launch[0];
        tgt = m_loads[0] + 2;
        @(posedge clk);
        #2 start[0] = 1'b1;
        for (int n = 0; n < 100 && m_launch[0] < l0 + 2; n++) @(posedge clk);
        #2 start[0] = 1'b0;
        wait_loads(0, tgt);

        tgt = m_loads[0] + 1;
        pulse(0);
        reset_after_writes(3);
        wait_loads(0, tgt);

        for (int it = 0; it < 8; it++) begin
            sel = int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            if (sel == 2) begin
                tgt = m_loads[0] + 1;
                pulse(0);
                reset_after_writes(int'($urandom_range(1, 7)));
                wait_loads(0, tgt);
            end else begin
                base[sel] = $urandom;
                tgt = m_loads[sel] + 1;
                pulse(sel);
                wait_loads(sel, tgt);
            end
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
